uart_tx_core: RTL and testbench
===============================

Name: uart_tx_core

Overview:
UART transmitter; the transmit-side counterpart of the UART RX path in the same codebase.
- Accepts a parallel word with a valid strobe.
- Serialises it LSB-first as start, data, optional parity and stop bits on TX_OUT.
- Holds each bit for Prescale clock cycles, so it runs from the same oversampled clock as the receiver.
- Sits between the system-side register/FIFO interface and the serial line.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_BITS, 5, width of Prescale input and internal per-bit cycle counter

Ports:
CLK  input  1  clock, rising edge active (oversampled clock, Prescale cycles per serial bit)
RST  input  1  reset, asynchronous, active-low
P_DATA  input  DATA_WIDTH  parallel data to send
DATA_VALID  input  1  request; word accepted on a rising edge where DATA_VALID=1 and Busy=0
PAR_EN  input  1  1 = insert parity bit after data
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Prescale  input  PRESCALE_BITS  clock cycles per serial bit
TX_OUT  output  1  serial line, registered, idle high
Busy  output  1  registered; high from frame accept until end of stop bit

Behaviour:
- Reset (RST=0, asynchronous): TX_OUT=1, Busy=0, FSM=IDLE, all counters and latches cleared. Asserting RST mid-frame aborts the frame immediately and drives TX_OUT=1 with no glitch to 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1.
  - On an edge with DATA_VALID=1 (Busy is 0 in IDLE), the following are latched: P_DATA, PAR_EN, PAR_TYP, Prescale.
  - Parity is computed on the latched data: even parity = ^P_DATA; odd parity = ~^P_DATA.
  - Same edge: TX_OUT<=0, Busy<=1, go to START, clear bit-cycle counter. Accept-to-line latency is 0 cycles after the accepting edge.
- Bit timing:
  - Each state lasts exactly Pl cycles, where Pl is the latched Prescale.
  - Pl=0 is treated as 1.
  - The cycle counter counts 0..Pl-1; the transition occurs on the edge where counter==Pl-1.
- START: TX_OUT=0 for Pl cycles, then go to DATA with bit index 0.
- DATA:
  - TX_OUT = data[idx], LSB first.
  - After Pl cycles idx increments. After idx DATA_WIDTH-1 completes, go to PARITY if PAR_EN latched, else STOP.
- PARITY: TX_OUT = latched parity bit for Pl cycles, then go to STOP.
- STOP: TX_OUT=1 for Pl cycles; on the final edge Busy<=0 and go to IDLE.
- Frame length:
  - F = (DATA_WIDTH+2+PAR_EN)*Pl cycles.
  - Busy is high for exactly F cycles.
- Back-to-back: DATA_VALID is ignored while Busy=1. If DATA_VALID is high when Busy falls, the next word is accepted on the following edge, giving a minimum of 1 idle-high cycle between frames.
- Input stability: P_DATA, PAR_EN, PAR_TYP and Prescale changes during a frame have no effect on that frame.
- TX_OUT and Busy are driven directly from flops; no combinational path from inputs to outputs.

Test Plan:
- Reset, then Prescale=8, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, 1-cycle DATA_VALID pulse:
  - TX_OUT bit sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit exactly 8 cycles.
  - Busy high 88 cycles, then TX_OUT=1.
- Prescale=4, P_DATA=0x01, PAR_EN=1:
  - PAR_TYP=1 gives parity bit 0.
  - PAR_TYP=0 gives parity bit 1.
  - Frame length 44 cycles.
- Prescale=4, P_DATA=0xFF, PAR_EN=0: 10 bits, no parity slot; Busy high exactly 40 cycles.
- DATA_VALID held high continuously with 0x3C then 0xC3, and P_DATA changed mid-frame:
  - The first frame is unaffected by the P_DATA change.
  - Exactly 1 idle-high cycle separates the frames.
  - The second frame carries the word present at its accept edge.
- Assert RST at cycle 20 of a Prescale=8 frame: TX_OUT=1 and Busy=0 immediately. After release, a new 0x55 frame transmits correctly.
- Prescale=1 and Prescale=0, P_DATA=0x96, PAR_EN=1, PAR_TYP=1: one cycle per bit, 11-cycle frame in both cases, parity bit 1.

Source files
------------

// File: rtl/uart_tx_core.sv
// UART transmitter: serialises a parallel word LSB-first as start, data, optional parity and stop bits,
// holding every bit for a latched number of oversampled clock cycles.
module uart_tx_core #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned PRESCALE_BITS = 5
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [DATA_WIDTH-1:0]    P_DATA,
   input  logic                     DATA_VALID,
   input  logic                     PAR_EN,
   input  logic                     PAR_TYP,
   input  logic [PRESCALE_BITS-1:0] Prescale,
   output logic                     TX_OUT,
   output logic                     Busy
);

   localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                   r_state;
   logic [DATA_WIDTH-1:0]    r_shift;
   logic                     r_par_en;
   logic                     r_par_bit;
   logic [PRESCALE_BITS-1:0] r_pl;
   logic [PRESCALE_BITS-1:0] r_cnt;
   logic [IDX_W-1:0]         r_idx;
   logic                     r_tx;
   logic                     r_busy;

   logic                     w_bit_done;
   logic                     w_last_data;
   logic [DATA_WIDTH-1:0]    w_shift_nxt;

   assign w_bit_done  = (r_cnt == (r_pl - PRESCALE_BITS'(1)));
   assign w_last_data = (r_idx == IDX_W'(DATA_WIDTH - 1));
   assign w_shift_nxt = r_shift >> 1;

   assign TX_OUT = r_tx;
   assign Busy   = r_busy;

   // Frame sequencer; the line value for each bit is loaded on the edge that enters that bit
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_par_en  <= 1'b0;
         r_par_bit <= 1'b0;
         r_pl      <= '0;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         if (r_state != S_IDLE) begin
            r_cnt <= w_bit_done ? '0 : r_cnt + PRESCALE_BITS'(1);
         end
         case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (DATA_VALID) begin
                  r_shift   <= P_DATA;
                  r_par_en  <= PAR_EN;
                  r_par_bit <= PAR_TYP ? ~^P_DATA : ^P_DATA;
                  r_pl      <= (Prescale == '0) ? PRESCALE_BITS'(1) : Prescale;
                  r_cnt     <= '0;
                  r_idx     <= '0;
                  r_tx      <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= S_START;
               end
            end
            S_START: begin
               if (w_bit_done) begin
                  r_idx   <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_bit_done) begin
                  if (w_last_data) begin
                     if (r_par_en) begin
                        r_tx    <= r_par_bit;
                        r_state <= S_PARITY;
                     end else begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                     end
                  end else begin
                     r_idx   <= r_idx + IDX_W'(1);
                     r_shift <= w_shift_nxt;
                     r_tx    <= w_shift_nxt[0];
                  end
               end
            end
            S_PARITY: begin
               if (w_bit_done) begin
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_bit_done) begin
                  r_tx    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: per-cycle comparison against a frame-level model plus directed literal frames.
module tb_uart_tx_core;

   localparam int unsigned DW = 8;
   localparam int unsigned PB = 5;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [DW-1:0] P_DATA = '0;
   logic          DATA_VALID = 1'b0;
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic [PB-1:0] Prescale = '0;
   logic          TX_OUT;
   logic          Busy;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   uart_tx_core #(.DATA_WIDTH(DW), .PRESCALE_BITS(PB)) dut (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
      .TX_OUT(TX_OUT), .Busy(Busy)
   );

   always #5 CLK = ~CLK;

   // Frame-level model: list of serial bits, cycles per bit, elapsed cycles in frame
   bit m_bits[0:15];
   int m_nb, m_pl, m_len, m_k;
   bit m_busy = 1'b0;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         m_busy = 1'b0;
         m_k    = 0;
      end else if (m_busy) begin
         m_k++;
         if (m_k == m_len) m_busy = 1'b0;
      end else if (DATA_VALID) begin
         m_pl = (Prescale == 0) ? 1 : int'(Prescale);
         m_nb = 0;
         m_bits[m_nb++] = 1'b0;
         for (int i = 0; i < DW; i++) m_bits[m_nb++] = P_DATA[i];
         if (PAR_EN) m_bits[m_nb++] = (($countones(P_DATA) % 2) == 1) ^ PAR_TYP;
         m_bits[m_nb++] = 1'b1;
         m_len  = m_nb * m_pl;
         m_k    = 0;
         m_busy = 1'b1;
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         logic exp_tx;
         exp_tx = m_busy ? m_bits[m_k / m_pl] : 1'b1;
         checks++;
         if (TX_OUT !== exp_tx || Busy !== m_busy) begin
            errors++;
            $display("FAIL cycle_model t=%0t tx=%b busy=%b expected tx=%b busy=%b",
                     $time, TX_OUT, Busy, exp_tx, m_busy);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Waits (bounded) for Busy, then records TX_OUT every cycle of the frame
   task automatic capture(input int pl, input int chg_at, input logic [DW-1:0] chg_val,
                          input bit drop_dv, output int len, output logic [15:0] bits,
                          output bit uniform, output int wait_cyc);
      bit q[0:1023];
      wait_cyc = 0;
      len = 0;
      bits = '0;
      uniform = 1'b1;
      do begin
         @(negedge CLK);
         wait_cyc++;
      end while (!Busy && wait_cyc < 50);
      while (Busy && len < 1000) begin
         if (drop_dv) DATA_VALID = 1'b0;
         q[len] = TX_OUT;
         if (len == chg_at) P_DATA = chg_val;
         len++;
         @(negedge CLK);
      end
      for (int k = 0; k < len; k++) if (q[k] != q[(k / pl) * pl]) uniform = 1'b0;
      for (int i = 0; i < 16; i++) if (i * pl < len) bits[i] = q[i * pl];
   endtask

   task automatic run_frame(input string name, input logic [DW-1:0] d, input bit en, input bit typ,
                            input logic [PB-1:0] pre, input int exp_len, input logic [15:0] exp_bits);
      int len, wc, pl;
      logic [15:0] bits;
      bit uni;
      pl = (pre == 0) ? 1 : int'(pre);
      P_DATA = d; PAR_EN = en; PAR_TYP = typ; Prescale = pre; DATA_VALID = 1'b1;
      capture(pl, -1, '0, 1'b1, len, bits, uni, wc);
      chk({name, "_accept_latency"}, wc, 1);
      chk({name, "_busy_len"}, len, exp_len);
      chk({name, "_bits"}, int'(bits), int'(exp_bits));
      chk({name, "_bit_width"}, int'(uni), 1);
      chk({name, "_idle_tx"}, int'(TX_OUT), 1);
   endtask

   initial begin
      int len, wc;
      logic [15:0] bits;
      bit uni;

      repeat (3) @(negedge CLK);
      chk("reset_tx", int'(TX_OUT), 1);
      chk("reset_busy", int'(Busy), 0);
      #2 RST = 1'b1;
      chk_en = 1'b1;
      @(negedge CLK);

      run_frame("a5_par_even", 8'hA5, 1'b1, 1'b0, 5'd8, 88, 16'({1'b1, 1'b0, 8'hA5, 1'b0}));
      @(negedge CLK);
      run_frame("01_par_odd", 8'h01, 1'b1, 1'b1, 5'd4, 44, 16'({1'b1, 1'b0, 8'h01, 1'b0}));
      run_frame("01_par_even", 8'h01, 1'b1, 1'b0, 5'd4, 44, 16'({1'b1, 1'b1, 8'h01, 1'b0}));
      run_frame("ff_nopar", 8'hFF, 1'b0, 1'b0, 5'd4, 40, 16'({1'b1, 8'hFF, 1'b0}));
      run_frame("96_pre1", 8'h96, 1'b1, 1'b1, 5'd1, 11, 16'({1'b1, 1'b1, 8'h96, 1'b0}));
      run_frame("96_pre0", 8'h96, 1'b1, 1'b1, 5'd0, 11, 16'({1'b1, 1'b1, 8'h96, 1'b0}));

      // Back-to-back with DATA_VALID held and P_DATA changed mid-frame
      P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 5'd4; DATA_VALID = 1'b1;
      capture(4, 10, 8'hC3, 1'b0, len, bits, uni, wc);
      chk("b2b_first_len", len, 40);
      chk("b2b_first_bits", int'(bits), int'(16'({1'b1, 8'h3C, 1'b0})));
      chk("b2b_gap_tx", int'(TX_OUT), 1);
      capture(4, -1, '0, 1'b1, len, bits, uni, wc);
      chk("b2b_idle_gap", wc, 1);
      chk("b2b_second_bits", int'(bits), int'(16'({1'b1, 8'hC3, 1'b0})));
      chk("b2b_second_uniform", int'(uni), 1);

      // Asynchronous reset in the middle of a frame
      @(negedge CLK);
      P_DATA = 8'h0F; PAR_EN = 1'b1; Prescale = 5'd8; DATA_VALID = 1'b1;
      wc = 0;
      do begin
         @(negedge CLK);
         wc++;
      end while (!Busy && wc < 50);
      chk("rst_frame_started", int'(Busy), 1);
      DATA_VALID = 1'b0;
      repeat (19) @(negedge CLK);
      #2 RST = 1'b0;
      #1;
      chk("rst_mid_tx", int'(TX_OUT), 1);
      chk("rst_mid_busy", int'(Busy), 0);
      repeat (3) @(negedge CLK);
      #2 RST = 1'b1;
      @(negedge CLK);
      run_frame("55_after_rst", 8'h55, 1'b1, 1'b0, 5'd8, 88, 16'({1'b1, 1'b0, 8'h55, 1'b0}));

      // Random traffic with inputs changing freely; the per-cycle model does the checking
      for (int c = 0; c < 4000; c++) begin
         @(negedge CLK);
         if ($urandom_range(0, 3) == 0) DATA_VALID = 1'($urandom_range(0, 1));
         P_DATA   = DW'($urandom);
         PAR_EN   = 1'($urandom_range(0, 1));
         PAR_TYP  = 1'($urandom_range(0, 1));
         Prescale = PB'($urandom_range(0, 5));
         if (c == 2000) begin
            #2 RST = 1'b0;
            @(negedge CLK);
            #2 RST = 1'b1;
         end
      end
      DATA_VALID = 1'b0;
      repeat (200) @(negedge CLK);
      chk("final_idle_busy", int'(Busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

endmodule
